// File: rtl/odd_even_seq_arbiter_if.sv
// odd_even_seq_arbiter_if: request side and shared sequence outputs of the arbiter
interface odd_even_seq_arbiter_if #(parameter int N = 4, parameter int W = 4, parameter int LW = 4);
  logic [N-1:0] req;
  logic [N-1:0] req_odd;
  logic [N*LW-1:0] req_len;
  logic hold;
  logic [N-1:0] gnt;
  logic busy;
  logic [W-1:0] cnt;
  logic cnt_vld;
  logic last;
  logic done;
  logic aborted;
  modport master(output req, req_odd, req_len, hold, input gnt, busy, cnt, cnt_vld, last, done, aborted);
  modport slave(input req, req_odd, req_len, hold, output gnt, busy, cnt, cnt_vld, last, done, aborted);
endinterface

// File: rtl/odd_even_seq_arbiter.sv
// odd_even_seq_arbiter: round-robin sharing of one odd/even step-by-2 counter among N clients
module odd_even_seq_arbiter #(parameter int N = 4, parameter int W = 4, parameter int LW = 4) (
  input logic clk,
  input logic rst,
  odd_even_seq_arbiter_if.slave bus
);
  localparam int PW = $clog2(N);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t st, st_nx;
  logic [PW-1:0] ptr, win, sel, j;
  logic [W-1:0] cnt;
  logic [LW-1:0] rem;
  logic ab, vld, lst, abt;
  // first requester at or after ptr; scanning downward lets the nearest offset win
  always_comb begin
    sel = ptr;
    j = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = PW'((int'(ptr) + i) % N);
      if (bus.req[j]) sel = j;
    end
  end
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) st <= IDLE;
    else st <= st_nx;
  // next state and outputs; a dropped request ends the burst even while held
  always_comb begin
    vld = st == RUN && !bus.hold && bus.req[win];
    lst = vld && rem == '0;
    abt = st == RUN && !bus.req[win];
    st_nx = st == IDLE ? (|bus.req ? RUN : IDLE) : st == RUN ? ((abt || lst) ? DONE : RUN) : IDLE;
    bus.gnt = st == RUN ? N'(1) << win : '0;
    bus.busy = st != IDLE;
    bus.cnt = cnt;
    bus.cnt_vld = vld;
    bus.last = lst;
    bus.done = st == DONE;
    bus.aborted = st == DONE && ab;
  end
  // grant latch, counter datapath and rotation pointer
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ptr <= '0;
      win <= '0;
      cnt <= '0;
      rem <= '0;
      ab <= 1'b0;
    end else begin
      if (st == IDLE && |bus.req) begin
        win <= sel;
        rem <= bus.req_len[int'(sel) * LW +: LW];
        cnt <= W'(bus.req_odd[sel]);
      end
      if (vld && rem != '0) begin
        cnt <= cnt + W'(2);
        rem <= rem - LW'(1);
      end
      if (abt) ab <= 1'b1;
      else if (lst) ab <= 1'b0;
      if (st == DONE) ptr <= win == PW'(N - 1) ? '0 : win + PW'(1);
    end
endmodule
